// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and constants for the intersection phase scheduler:
// phase codes, light encodings and light-decode helpers.
package traffic_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_PED_WALK    = 3'd5,
    ST_ALL_RED_B   = 3'd6
  } phase_t;

  // Light buses are {red, yellow, green}, one-hot.
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic logic [2:0] main_lights_of(input phase_t s);
    logic [2:0] l;
    l = RED;
    case (s)
      ST_MAIN_GREEN:  l = GRN;
      ST_MAIN_YELLOW: l = YEL;
      default:        l = RED;
    endcase
    return l;
  endfunction

  function automatic logic [2:0] side_lights_of(input phase_t s);
    logic [2:0] l;
    l = RED;
    case (s)
      ST_SIDE_GREEN:  l = GRN;
      ST_SIDE_YELLOW: l = YEL;
      default:        l = RED;
    endcase
    return l;
  endfunction

  function automatic logic walk_of(input phase_t s);
    return (s == ST_PED_WALK);
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_if.sv
// Request/timebase inputs and light outputs of the phase scheduler.
// master drives requests and tick; slave is the scheduler.
interface traffic_phase_scheduler_if;

  logic       tick;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_road_lights;
  logic [2:0] side_road_lights;
  logic       ped_walk;
  logic [2:0] phase;

  modport master (
    output tick,
    output side_req,
    output ped_req,
    input  main_road_lights,
    input  side_road_lights,
    input  ped_walk,
    input  phase
  );

  modport slave (
    input  tick,
    input  side_req,
    input  ped_req,
    output main_road_lights,
    output side_road_lights,
    output ped_walk,
    output phase
  );

endinterface

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Loadable down-counter for phase durations: load wins, otherwise counts
// down on tick and parks at zero.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Intersection sequencer: main road rests on green, latched side/ped
// requests are granted through yellow and all-red clearance phases.
module traffic_phase_scheduler
  import traffic_phase_scheduler_pkg::*;
#(
  parameter int unsigned MAIN_MIN_GREEN = 8,
  parameter int unsigned SIDE_GREEN     = 5,
  parameter int unsigned YELLOW         = 2,
  parameter int unsigned ALL_RED        = 1,
  parameter int unsigned PED_WALK       = 4,
  parameter int unsigned CNT_W          = 8
) (
  input logic                     clk,
  input logic                     start,
  traffic_phase_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] MAIN_LD  = CNT_W'(MAIN_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] SIDE_LD  = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LD   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RED_LD   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(PED_WALK - 1);

  phase_t           state_q;
  phase_t           state_d;
  logic             side_pend;
  logic             ped_pend;
  logic             rr;
  logic             advance;
  logic             timer_zero;
  logic             timer_load;
  logic [CNT_W-1:0] load_val;
  logic             grant_side;
  logic             grant_ped;

  function automatic logic [CNT_W-1:0] load_for(input phase_t s);
    logic [CNT_W-1:0] v;
    v = MAIN_LD;
    case (s)
      ST_MAIN_GREEN:  v = MAIN_LD;
      ST_MAIN_YELLOW: v = YEL_LD;
      ST_ALL_RED_A:   v = RED_LD;
      ST_SIDE_GREEN:  v = SIDE_LD;
      ST_SIDE_YELLOW: v = YEL_LD;
      ST_PED_WALK:    v = WALK_LD;
      ST_ALL_RED_B:   v = RED_LD;
      default:        v = MAIN_LD;
    endcase
    return v;
  endfunction

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .tick     (bus.tick),
    .load     (timer_load),
    .load_val (load_val),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d = state_q;
    if (bus.tick && timer_zero) begin
      case (state_q)
        ST_MAIN_GREEN: begin
          if (side_pend || ped_pend) state_d = ST_MAIN_YELLOW;
        end
        ST_MAIN_YELLOW: state_d = ST_ALL_RED_A;
        ST_ALL_RED_A: begin
          // rr breaks the tie when both are waiting; neither pending only
          // arises from an unreachable path, so return to main safely.
          if (side_pend && ped_pend) state_d = rr ? ST_PED_WALK : ST_SIDE_GREEN;
          else if (side_pend)        state_d = ST_SIDE_GREEN;
          else if (ped_pend)         state_d = ST_PED_WALK;
          else                       state_d = ST_ALL_RED_B;
        end
        ST_SIDE_GREEN:  state_d = ST_SIDE_YELLOW;
        ST_SIDE_YELLOW: state_d = ST_ALL_RED_B;
        ST_PED_WALK:    state_d = ST_ALL_RED_B;
        ST_ALL_RED_B:   state_d = ST_MAIN_GREEN;
        default:        state_d = ST_MAIN_GREEN;
      endcase
    end
  end

  always_comb begin
    advance    = (state_d != state_q);
    grant_side = advance && (state_d == ST_SIDE_GREEN);
    grant_ped  = advance && (state_d == ST_PED_WALK);
    timer_load = !start || advance;
    load_val   = start ? load_for(state_d) : MAIN_LD;
  end

  // Lights decode from the next state so they are registered alongside it.
  always_ff @(posedge clk) begin
    if (!start) begin
      state_q              <= ST_MAIN_GREEN;
      side_pend            <= 1'b0;
      ped_pend             <= 1'b0;
      rr                   <= 1'b0;
      bus.main_road_lights <= GRN;
      bus.side_road_lights <= RED;
      bus.ped_walk         <= 1'b0;
    end else begin
      state_q              <= state_d;
      bus.main_road_lights <= main_lights_of(state_d);
      bus.side_road_lights <= side_lights_of(state_d);
      bus.ped_walk         <= walk_of(state_d);
      side_pend            <= grant_side ? 1'b0 : (side_pend | bus.side_req);
      ped_pend             <= grant_ped  ? 1'b0 : (ped_pend  | bus.ped_req);
      if (grant_side)     rr <= 1'b1;
      else if (grant_ped) rr <= 1'b0;
    end
  end

  assign bus.phase = state_q;

  safe_roads: assert property (@(posedge clk) disable iff (!start)
    !((bus.main_road_lights != RED) && (bus.side_road_lights != RED)));

  safe_walk: assert property (@(posedge clk) disable iff (!start)
    !(bus.ped_walk && ((bus.main_road_lights != RED) || (bus.side_road_lights != RED))));

  onehot_lights: assert property (@(posedge clk) disable iff (!start)
    $onehot(bus.main_road_lights) && $onehot(bus.side_road_lights));

endmodule
